// File: rtl/video_rx_capture_pkg.sv
// Shared types and constants for the parallel video capture path.
// State encoding, pixel/word widths and the saturating counter helper.
package video_rx_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    IN_VS   = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

  localparam int PIX_W      = 16;
  localparam int WORD_W     = 2 * PIX_W;
  localparam int ENTRY_W    = WORD_W + 2;
  localparam int CNT_W      = 12;
  localparam int H_ACT_720P = 1280;
  localparam int V_ACT_720P = 720;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/video_rx_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible while not empty.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module video_rx_fifo
  import video_rx_capture_pkg::*;
#(
  parameter int DW = ENTRY_W,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/video_rx_capture.sv
// Video sink: locks to frame start, packs RGB565 pixel pairs into 32-bit words,
// queues them for the frame-buffer writer and measures per-frame active geometry.
module video_rx_capture
  import video_rx_capture_pkg::*;
#(
  parameter int H_ACT   = H_ACT_720P,
  parameter int V_ACT   = V_ACT_720P,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        de_in,
  input  logic [15:0] pin,
  output logic [31:0] wr_data,
  output logic        wr_sof,
  output logic        wr_eol,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [11:0] h_meas,
  output logic [11:0] v_meas,
  output logic        frame_ok,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACT);

  rx_state_e state_q, state_d;

  logic vs_q, vs_prev_q, de_q, de_prev_q, hs_unused_q;
  logic [PIX_W-1:0] pix_q;

  logic              slot_full_q, slot_full_d;
  logic [PIX_W-1:0]  slot_q, slot_d;
  logic              stg_vld_q, stg_vld_d;
  logic              stg_sof_q, stg_sof_d;
  logic              stg_eol_q, stg_eol_d;
  logic [WORD_W-1:0] stg_data_q, stg_data_d;
  logic              sof_pend_q, sof_pend_d;
  logic              line_open_q, line_open_d;

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic             line_bad_q, line_bad_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic [CNT_W-1:0] h_meas_q, h_meas_d;
  logic [CNT_W-1:0] v_meas_q, v_meas_d;
  logic             frame_ok_q, frame_ok_d;
  logic             overflow_q, overflow_d;

  logic vs_rise, vs_fall, cap, pix_en, line_close, frame_end;
  logic push_eol, drop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] lines_now;
  logic bad_now, ovf_now;
  logic [FIFO_AW:0] fifo_cnt_unused;

  // Stage 0: register raw inputs; all detection uses the registered copies
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      de_q      <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      vs_q      <= vs_in;
      vs_prev_q <= vs_q;
      de_q      <= de_in;
      de_prev_q <= de_q;
    end
  end

  always_ff @(posedge clk) begin
    pix_q       <= pin;
    hs_unused_q <= hs_in;
    slot_q      <= slot_d;
    stg_data_q  <= stg_data_d;
  end

  assign vs_rise    = vs_q & ~vs_prev_q;
  assign vs_fall    = ~vs_q & vs_prev_q;
  assign cap        = (state_q == ACTIVE);
  // A vs rise during de ends the line in the same cycle; that pixel is not taken
  assign pix_en     = cap & de_q & ~vs_rise;
  assign line_close = line_open_q & (~de_q | vs_rise);
  assign frame_end  = cap & vs_rise;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_VS: if (vs_rise) state_d = IN_VS;
      IN_VS:   if (vs_fall) state_d = ACTIVE;
      ACTIVE:  if (vs_rise) state_d = IN_VS;
      default: state_d = WAIT_VS;
    endcase
  end

  // Stage 1: pair packing into a one-word staging register
  always_comb begin
    slot_full_d = slot_full_q;
    slot_d      = slot_q;
    stg_vld_d   = 1'b0;
    stg_sof_d   = 1'b0;
    stg_eol_d   = 1'b0;
    stg_data_d  = stg_data_q;
    sof_pend_d  = sof_pend_q;
    line_open_d = line_open_q;
    if (state_q == IN_VS && vs_fall) sof_pend_d = 1'b1;
    if (pix_en) begin
      line_open_d = 1'b1;
      if (!slot_full_q) begin
        slot_d      = pix_q;
        slot_full_d = 1'b1;
      end else begin
        stg_vld_d   = 1'b1;
        stg_data_d  = {pix_q, slot_q};
        slot_full_d = 1'b0;
      end
    end else if (line_close) begin
      line_open_d = 1'b0;
      if (slot_full_q) begin
        stg_vld_d   = 1'b1;
        stg_eol_d   = 1'b1;
        stg_data_d  = {16'h0000, slot_q};
        slot_full_d = 1'b0;
      end
    end
    if (stg_vld_d) begin
      stg_sof_d  = sof_pend_q;
      sof_pend_d = 1'b0;
    end
  end

  // An even-length line closes while its last pair sits in the stage
  assign push_eol = stg_eol_q | line_close;
  assign drop     = stg_vld_q & fifo_full & ~wr_ready;

  // Stage 2: measurement and status
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    h_meas_d   = h_meas_q;
    v_meas_d   = v_meas_q;
    frame_ok_d = frame_ok_q;
    lines_now  = line_cnt_q;
    bad_now    = line_bad_q;
    ovf_now    = frame_ovf_q | drop;
    if (pix_en) pix_cnt_d = line_open_q ? cnt_sat_inc(pix_cnt_q) : CNT_W'(1);
    if (line_close) begin
      h_meas_d  = pix_cnt_q;
      lines_now = cnt_sat_inc(line_cnt_q);
      bad_now   = line_bad_q | (pix_cnt_q != H_ACT_C);
    end
    line_cnt_d  = lines_now;
    line_bad_d  = bad_now;
    frame_ovf_d = ovf_now;
    if (frame_end) begin
      v_meas_d    = lines_now;
      frame_ok_d  = (lines_now == V_ACT_C) & ~bad_now & ~ovf_now;
      line_cnt_d  = '0;
      line_bad_d  = 1'b0;
      frame_ovf_d = 1'b0;
    end
    overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_VS;
      slot_full_q <= 1'b0;
      stg_vld_q   <= 1'b0;
      stg_sof_q   <= 1'b0;
      stg_eol_q   <= 1'b0;
      sof_pend_q  <= 1'b0;
      line_open_q <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      line_bad_q  <= 1'b0;
      frame_ovf_q <= 1'b0;
      h_meas_q    <= '0;
      v_meas_q    <= '0;
      frame_ok_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      stg_vld_q   <= stg_vld_d;
      stg_sof_q   <= stg_sof_d;
      stg_eol_q   <= stg_eol_d;
      sof_pend_q  <= sof_pend_d;
      line_open_q <= line_open_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_bad_q  <= line_bad_d;
      frame_ovf_q <= frame_ovf_d;
      h_meas_q    <= h_meas_d;
      v_meas_q    <= v_meas_d;
      frame_ok_q  <= frame_ok_d;
      overflow_q  <= overflow_d;
    end
  end

  video_rx_fifo #(
    .DW (ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (stg_vld_q),
    .din_i   ({stg_sof_q, push_eol, stg_data_q}),
    .pop_i   (wr_ready),
    .dout_o  ({wr_sof, wr_eol, wr_data}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt_unused)
  );

  assign wr_valid = ~fifo_empty;
  assign h_meas   = h_meas_q;
  assign v_meas   = v_meas_q;
  assign frame_ok = frame_ok_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_video_rx_capture.sv
// Bench for video_rx_capture: random-pixel frames on a reduced raster, words
// scored against a per-line packing model, plus stall, overflow and reset cases.
module tb_video_rx_capture;

  localparam int H  = 48;
  localparam int V  = 4;
  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst, vs_in, hs_in, de_in, ovf_clr;
  logic [15:0] pin;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_data;
  logic        wr_sof, wr_eol, wr_valid, frame_ok, overflow;
  logic [11:0] h_meas, v_meas;

  int total = 0;
  int bad   = 0;
  int rdy_toggle = 0;
  int stall_left = 0;

  logic [33:0] rx_q[$];
  logic [33:0] exp_q[$];
  logic [15:0] line_px[$];
  logic [33:0] held;
  bit          stalled = 1'b0;

  video_rx_capture #(.H_ACT(H), .V_ACT(V), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .vs_in    (vs_in),
    .hs_in    (hs_in),
    .de_in    (de_in),
    .pin      (pin),
    .wr_data  (wr_data),
    .wr_sof   (wr_sof),
    .wr_eol   (wr_eol),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .h_meas   (h_meas),
    .v_meas   (v_meas),
    .frame_ok (frame_ok),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer: always ready, toggling, or stalled for a requested number of cycles
  always begin
    @(posedge clk);
    #1;
    if (rdy_toggle != 0) wr_ready = ~wr_ready;
    else if (stall_left > 0) begin
      wr_ready = 1'b0;
      stall_left--;
    end else wr_ready = 1'b1;
  end

  // Collect accepted words and verify the head holds while stalled
  always @(negedge clk) begin
    if (stalled && wr_valid) check("hold", {wr_sof, wr_eol, wr_data}, held);
    if (wr_valid && wr_ready) rx_q.push_back({wr_sof, wr_eol, wr_data});
    stalled = wr_valid && !wr_ready && !rst;
    held    = {wr_sof, wr_eol, wr_data};
  end

  task automatic vs_pulse();
    vs_in = 1'b1;
    repeat (3) tick();
    vs_in = 1'b0;
    repeat (4) tick();
  endtask

  // Drives one frame of lines and appends the words a correct sink must emit
  task automatic send_frame(input int nlines, input int last_len, input bit fixed_first,
                            input int stall_line, input int rst_line);
    bit first_word = 1'b1;
    int len;
    logic [15:0] px;
    logic [31:0] w;
    for (int l = 0; l < nlines; l++) begin
      len = (l == nlines - 1) ? last_len : H;
      line_px.delete();
      if (l == stall_line) stall_left = 40;
      for (int i = 0; i < len; i++) begin
        px = (fixed_first && l == 0 && i < 2) ? 16'(i + 1) : 16'($urandom);
        if (l == rst_line && i == 3) rst = 1'b1;
        if (l == rst_line && i == 5) begin
          rst = 1'b0;
          rx_q.delete();
        end
        pin   = px;
        de_in = 1'b1;
        line_px.push_back(px);
        tick();
      end
      de_in = 1'b0;
      tick();
      hs_in = 1'b1;
      repeat (2) tick();
      hs_in = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < len; i += 2) begin
        w = (i + 1 < len) ? {line_px[i+1], line_px[i]} : {16'h0000, line_px[i]};
        exp_q.push_back({first_word, (i + 2 >= len), w});
        first_word = 1'b0;
      end
    end
    repeat (30) tick();
  endtask

  task automatic score_frame(input string tag);
    int n;
    check({tag, "_nwords"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; pin = '0; ovf_clr = 1'b0;
    repeat (3) tick();
    check("rst_valid", wr_valid, 0);
    check("rst_data", wr_data, 0);
    check("rst_hmeas", h_meas, 0);
    check("rst_vmeas", v_meas, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Frame with a known first pair, consumer always ready
    vs_pulse();
    send_frame(V, H, 1'b1, -1, -1);
    if (rx_q.size() > 0) check("first_word", rx_q[0], {1'b1, 1'b0, 32'h0002_0001});
    vs_pulse();
    score_frame("A");
    check("A_frame_ok", frame_ok, 1);
    check("A_hmeas", h_meas, H);
    check("A_vmeas", v_meas, V);
    check("A_overflow", overflow, 0);

    // Consumer toggling ready every cycle
    rdy_toggle = 1;
    send_frame(V, H, 1'b0, -1, -1);
    vs_pulse();
    rdy_toggle = 0;
    score_frame("B");
    check("B_frame_ok", frame_ok, 1);

    // Short odd-length last line
    send_frame(V, 5, 1'b0, -1, -1);
    vs_pulse();
    score_frame("C");
    check("C_frame_ok", frame_ok, 0);
    check("C_hmeas", h_meas, 5);
    check("C_vmeas", v_meas, V);

    // 40-cycle stall at line start overruns the FIFO
    send_frame(V, H, 1'b0, 0, -1);
    vs_pulse();
    check("D_overflow", overflow, 1);
    check("D_frame_ok", frame_ok, 0);
    rx_q.delete();
    exp_q.delete();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    check("D_ovf_clr", overflow, 0);

    send_frame(V, H, 1'b0, -1, -1);
    vs_pulse();
    score_frame("E");
    check("E_frame_ok", frame_ok, 1);
    check("E_overflow", overflow, 0);

    // Reset during active video: nothing until the next frame start
    send_frame(V, H, 1'b0, -1, 1);
    exp_q.delete();
    vs_pulse();
    check("F_nowords", rx_q.size(), 0);
    check("F_frame_ok", frame_ok, 0);
    check("F_vmeas", v_meas, 0);

    send_frame(V, H, 1'b0, -1, -1);
    if (rx_q.size() > 0) check("G_sof", rx_q[0][33], 1);
    vs_pulse();
    score_frame("G");
    check("G_frame_ok", frame_ok, 1);
    check("G_hmeas", h_meas, H);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
